// File: rtl/bomb_pkg.sv
// Shared encodings for the bomb game stages: game state and register control.
package bomb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    DEFUSED  = 2'd2,
    EXPLODED = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    LOAD = 2'd1,
    INCR = 2'd2,
    DECR = 2'd3
  } reg_op_t;

endpackage

// File: rtl/bomb_register.sv
// Loadable up/down counter shared by the bomb stages; saturates at both ends.
module bomb_register
  import bomb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             async_reset,
  input  reg_op_t          op,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value
);

  // Saturating so a stray INCR/DECR can never wrap the count.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      value <= {WIDTH{1'b0}};
    end else begin
      case (op)
        LOAD: value <= load_value;
        INCR: if (value != {WIDTH{1'b1}}) value <= value + {{(WIDTH-1){1'b0}}, 1'b1};
        DECR: if (value != {WIDTH{1'b0}}) value <= value - {{(WIDTH-1){1'b0}}, 1'b1};
        NONE: value <= value;
        default: value <= value;
      endcase
    end
  end

endmodule

// File: rtl/bomb_countdown.sv
// Bomb game controller: arm, count down on second ticks, defuse or detonate.
module bomb_countdown
  import bomb_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int DEFAULT_TIME   = 60,
  parameter int WARN_THRESHOLD = 10
) (
  input  logic             clk,
  input  logic             async_reset,
  input  logic             arm,
  input  logic             defuse,
  input  logic             restart,
  input  logic [WIDTH-1:0] load_time,
  input  logic             half_second,
  input  logic             second,
  output logic             timer_enabled,
  output logic             timer_clear,
  output logic [WIDTH-1:0] remaining,
  output logic             led,
  output logic             warning,
  output logic             defused,
  output logic             exploded
);

  state_t           state;
  reg_op_t          reg_op;
  logic [WIDTH-1:0] reg_load;

  bomb_register #(.WIDTH(WIDTH)) u_remaining (
    .clk        (clk),
    .async_reset(async_reset),
    .op         (reg_op),
    .load_value (reg_load),
    .value      (remaining)
  );

  // Counter control: load on arm/restart, step down on a second tick while armed.
  always_comb begin
    reg_op   = NONE;
    reg_load = {WIDTH{1'b0}};
    case (state)
      IDLE: begin
        if (arm) begin
          reg_op   = LOAD;
          reg_load = (load_time == {WIDTH{1'b0}}) ? WIDTH'(DEFAULT_TIME) : load_time;
        end else begin
          reg_op = NONE;
        end
      end
      ARMED: begin
        if (!defuse && second && (remaining != {WIDTH{1'b0}})) begin
          reg_op = DECR;
        end else begin
          reg_op = NONE;
        end
      end
      DEFUSED, EXPLODED: begin
        if (restart) begin
          reg_op = LOAD;
        end else begin
          reg_op = NONE;
        end
      end
      default: reg_op = NONE;
    endcase
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state    <= IDLE;
      led      <= 1'b0;
      defused  <= 1'b0;
      exploded <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            state <= ARMED;
            led   <= 1'b0;
          end
        end
        ARMED: begin
          // Defuse wins over a tick; a detonating tick overrides the blink.
          if (defuse) begin
            state   <= DEFUSED;
            led     <= 1'b1;
            defused <= 1'b1;
          end else if (second && (remaining == {{(WIDTH-1){1'b0}}, 1'b1})) begin
            state    <= EXPLODED;
            led      <= 1'b0;
            exploded <= 1'b1;
          end else if (half_second) begin
            led <= ~led;
          end
        end
        DEFUSED: begin
          if (restart) begin
            state   <= IDLE;
            led     <= 1'b0;
            defused <= 1'b0;
          end
        end
        EXPLODED: begin
          if (restart) begin
            state    <= IDLE;
            led      <= 1'b0;
            exploded <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          led      <= 1'b0;
          defused  <= 1'b0;
          exploded <= 1'b0;
        end
      endcase
    end
  end

  assign timer_enabled = (state == ARMED);
  assign timer_clear   = (state != ARMED);
  assign warning       = (state == ARMED) && (remaining != {WIDTH{1'b0}}) &&
                         (remaining <= WIDTH'(WARN_THRESHOLD));

endmodule
